// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch definitions: condition codes and resolver FSM encoding,
// also used by the ID-stage control decode.
package branch_resolve_unit_pkg;

  localparam logic [4:0] BR_BEQ = 5'b01000;
  localparam logic [4:0] BR_BNE = 5'b01001;
  localparam logic [4:0] BR_BLT = 5'b01010;
  localparam logic [4:0] BR_BGE = 5'b01011;
  localparam logic [4:0] BR_BAL = 5'b01100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: compares operands per the
// condition code and flags codes that are not branch conditions.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        code_i,
  output logic              taken_o,
  output logic              bad_code_o
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    taken_o    = 1'b0;
    bad_code_o = 1'b0;
    case (code_i)
      BR_BEQ:  taken_o = (a_i == b_i);
      BR_BNE:  taken_o = (a_i != b_i);
      BR_BLT:  taken_o = (a_s < b_s);
      BR_BGE:  taken_o = (a_s >= b_s);
      BR_BAL:  taken_o = 1'b1;
      default: bad_code_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: registered one-cycle redirect/flush pulse,
// followed by a squash window that ignores wrong-path branches.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_W          = 8,
  parameter int DATA_W        = 32,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_EX_Branch,
  input  logic [4:0]        ID_EX_ALUOp,
  input  logic [PC_W-1:0]   ID_EX_PC,
  input  logic [DATA_W-1:0] ID_EX_ReadData1,
  input  logic [DATA_W-1:0] ID_EX_ReadData2,
  input  logic [DATA_W-1:0] ID_EX_SignExtImm,
  output logic              BranchTaken,
  output logic [PC_W-1:0]   BranchTarget,
  output logic              FlushIF_ID,
  output logic              FlushID_EX,
  output logic              BadCond,
  output logic [CNT_W-1:0]  TakenCount
);

  localparam int SQ_W = (SQUASH_CYCLES > 2) ? $clog2(SQUASH_CYCLES) : 1;
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  br_state_e        state_q, state_d;
  logic [SQ_W-1:0]  sq_cnt_q, sq_cnt_d;
  logic             taken_q, taken_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cond_taken;
  logic             cond_bad;
  logic [PC_W-1:0]  target_sum;

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .a_i        (ID_EX_ReadData1),
    .b_i        (ID_EX_ReadData2),
    .code_i     (ID_EX_ALUOp),
    .taken_o    (cond_taken),
    .bad_code_o (cond_bad)
  );

  // Only the low PC_W bits of the offset matter; the sum wraps modulo 2^PC_W.
  assign target_sum = ID_EX_PC + ID_EX_SignExtImm[PC_W-1:0];

  generate
    if (DATA_W > PC_W) begin : g_imm_hi
      logic unused_imm_hi;
      assign unused_imm_hi = ^ID_EX_SignExtImm[DATA_W-1:PC_W];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    taken_d  = 1'b0;
    target_d = target_q;
    bad_d    = bad_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ID_EX_Branch) begin
          if (cond_bad) begin
            bad_d = 1'b1;
          end else if (cond_taken) begin
            state_d  = ST_REDIRECT;
            taken_d  = 1'b1;
            target_d = target_sum;
            cnt_d    = sat_inc(cnt_q);
          end
        end
      end
      ST_REDIRECT: begin
        sq_cnt_d = SQ_LOAD;
        state_d  = (SQUASH_CYCLES > 1) ? ST_SQUASH : ST_IDLE;
      end
      ST_SQUASH: begin
        sq_cnt_d = sq_cnt_q - SQ_W'(1);
        if (sq_cnt_q <= SQ_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sq_cnt_q <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
    end
  end

  assign BranchTaken  = taken_q;
  assign FlushIF_ID   = taken_q;
  assign FlushID_EX   = taken_q;
  assign BranchTarget = target_q;
  assign BadCond      = bad_q;
  assign TakenCount   = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus hand sequences for
// squash, sticky bad code, async reset and counter saturation (CNT_W=2 copy).
module tb_branch_resolve_unit;

  localparam logic [4:0] C_BEQ = 5'b01000;
  localparam logic [4:0] C_BNE = 5'b01001;
  localparam logic [4:0] C_BLT = 5'b01010;
  localparam logic [4:0] C_BGE = 5'b01011;
  localparam logic [4:0] C_BAL = 5'b01100;
  localparam logic [4:0] C_BAD = 5'b11111;
  localparam logic [4:0] C_ZRO = 5'b00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        br;
  logic [4:0]  op;
  logic [7:0]  pc;
  logic [31:0] a, b, imm;

  logic        taken, fl1, fl2, badc;
  logic [7:0]  tgt;
  logic [15:0] cnt;
  logic        taken_s, fl1_s, fl2_s, badc_s;
  logic [7:0]  tgt_s;
  logic [1:0]  cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .PC_W(8), .DATA_W(32), .SQUASH_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .ID_EX_Branch(br), .ID_EX_ALUOp(op), .ID_EX_PC(pc),
    .ID_EX_ReadData1(a), .ID_EX_ReadData2(b), .ID_EX_SignExtImm(imm),
    .BranchTaken(taken), .BranchTarget(tgt), .FlushIF_ID(fl1), .FlushID_EX(fl2),
    .BadCond(badc), .TakenCount(cnt)
  );

  branch_resolve_unit #(
    .PC_W(8), .DATA_W(32), .SQUASH_CYCLES(2), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .ID_EX_Branch(br), .ID_EX_ALUOp(op), .ID_EX_PC(pc),
    .ID_EX_ReadData1(a), .ID_EX_ReadData2(b), .ID_EX_SignExtImm(imm),
    .BranchTaken(taken_s), .BranchTarget(tgt_s), .FlushIF_ID(fl1_s), .FlushID_EX(fl2_s),
    .BadCond(badc_s), .TakenCount(cnt_s)
  );

  typedef struct packed {
    logic        br;
    logic [4:0]  op;
    logic [7:0]  pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        taken;
    logic [7:0]  tgt;
    logic        badc;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic t, input logic [7:0] et,
                         input logic eb, input int ec);
    int ecs;
    ecs = (ec > 3) ? 3 : ec;
    chk({nm, "_pulse"}, {29'd0, taken, fl1, fl2}, {29'd0, {3{t}}});
    chk({nm, "_target"}, {24'd0, tgt}, {24'd0, et});
    chk({nm, "_badcond"}, {31'd0, badc}, {31'd0, eb});
    chk({nm, "_count"}, {16'd0, cnt}, ec);
    chk({nm, "_sat"}, {19'd0, taken_s, fl1_s, fl2_s, badc_s, tgt_s, cnt_s},
        {19'd0, {3{t}}, eb, et, ecs[1:0]});
  endtask

  task automatic drive(input logic vbr, input logic [4:0] vop, input logic [7:0] vpc,
                       input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vimm);
    @(negedge clk);
    br = vbr; op = vop; pc = vpc; a = va; b = vb; imm = vimm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ec;
    vecs[0]  = '{1'b1, C_BEQ, 8'd20,  32'd5,         32'd5,         32'd12,        1'b1, 8'd32,  1'b0};
    vecs[1]  = '{1'b1, C_BEQ, 8'd20,  32'd5,         32'd6,         32'd12,        1'b0, 8'd32,  1'b0};
    vecs[2]  = '{1'b1, C_BNE, 8'd40,  32'd5,         32'd6,         32'hFFFF_FFF0, 1'b1, 8'd24,  1'b0};
    vecs[3]  = '{1'b1, C_BNE, 8'd40,  32'd7,         32'd7,         32'd0,         1'b0, 8'd24,  1'b0};
    vecs[4]  = '{1'b1, C_BLT, 8'd100, 32'hFFFF_FFFF, 32'd1,         32'd4,         1'b1, 8'd104, 1'b0};
    vecs[5]  = '{1'b1, C_BLT, 8'd100, 32'd1,         32'hFFFF_FFFF, 32'd4,         1'b0, 8'd104, 1'b0};
    vecs[6]  = '{1'b1, C_BGE, 8'd60,  32'd1,         32'hFFFF_FFFF, 32'd2,         1'b1, 8'd62,  1'b0};
    vecs[7]  = '{1'b1, C_BGE, 8'd10,  32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd0,         1'b1, 8'd10,  1'b0};
    vecs[8]  = '{1'b1, C_BGE, 8'd10,  32'hFFFF_FFFE, 32'd3,         32'd0,         1'b0, 8'd10,  1'b0};
    vecs[9]  = '{1'b1, C_BAL, 8'd250, 32'd0,         32'd0,         32'd10,        1'b1, 8'd4,   1'b0};
    vecs[10] = '{1'b0, C_BEQ, 8'd77,  32'd1,         32'd1,         32'd1,         1'b0, 8'd4,   1'b0};
    vecs[11] = '{1'b0, C_BAD, 8'd77,  32'd1,         32'd1,         32'd1,         1'b0, 8'd4,   1'b0};
    vecs[12] = '{1'b1, C_BAD, 8'd5,   32'd0,         32'd0,         32'd3,         1'b0, 8'd4,   1'b1};
    vecs[13] = '{1'b1, C_ZRO, 8'd5,   32'd0,         32'd0,         32'd3,         1'b0, 8'd4,   1'b1};
    vecs[14] = '{1'b1, C_BAL, 8'd0,   32'd0,         32'd0,         32'd5,         1'b1, 8'd5,   1'b1};

    // Reset held with a live taken branch on the inputs
    rst = 1'b0; br = 1'b1; op = C_BAL;
    pc = 8'($urandom); a = $urandom; b = $urandom; imm = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 8'd0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1; br = 1'b0; a = 'x; b = 'x;
    repeat (2) @(posedge clk);
    #1;
    chk_all("post_reset", 1'b0, 8'd0, 1'b0, 0);

    ec = 0;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].br, vecs[i].op, vecs[i].pc, vecs[i].a, vecs[i].b, vecs[i].imm);
      if (vecs[i].taken) ec++;
      chk_all($sformatf("vec%0d", i), vecs[i].taken, vecs[i].tgt, vecs[i].badc, ec);
      drive(1'b0, C_BEQ, 8'd0, 32'd0, 32'd0, 32'd0);
      chk_all($sformatf("vec%0d_end", i), 1'b0, vecs[i].tgt, vecs[i].badc, ec);
      drive(1'b0, C_BEQ, 8'd0, 32'd0, 32'd0, 32'd0);
    end

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("rst2", 1'b0, 8'd0, 1'b0, 0);

    // Squash window: two held BALs ignored, the third accepted back-to-back
    drive(1'b1, C_BAL, 8'd1,  32'd0, 32'd0, 32'd1);
    chk_all("sq_first", 1'b1, 8'd2, 1'b0, 1);
    drive(1'b1, C_BAL, 8'd50, 32'd0, 32'd0, 32'd0);
    chk_all("sq_ign1", 1'b0, 8'd2, 1'b0, 1);
    drive(1'b1, C_BAL, 8'd50, 32'd0, 32'd0, 32'd0);
    chk_all("sq_ign2", 1'b0, 8'd2, 1'b0, 1);
    drive(1'b1, C_BAL, 8'd70, 32'd0, 32'd0, 32'd0);
    chk_all("sq_second", 1'b1, 8'd70, 1'b0, 2);

    // Bad codes during redirect/squash must not set BadCond
    drive(1'b1, C_BAD, 8'd0, 32'd0, 32'd0, 32'd0);
    chk_all("sqb1", 1'b0, 8'd70, 1'b0, 2);
    drive(1'b1, C_BAD, 8'd0, 32'd0, 32'd0, 32'd0);
    chk_all("sqb2", 1'b0, 8'd70, 1'b0, 2);
    drive(1'b1, C_BAL, 8'd3, 32'd0, 32'd0, 32'd0);
    chk_all("sq_third", 1'b1, 8'd3, 1'b0, 3);
    drive(1'b0, C_BAL, 8'd0, 32'd0, 32'd0, 32'd0);
    drive(1'b0, C_BAL, 8'd0, 32'd0, 32'd0, 32'd0);

    // Fourth taken: CNT_W=2 copy saturates at 3, then async reset mid-REDIRECT
    drive(1'b1, C_BAL, 8'd9, 32'd0, 32'd0, 32'd0);
    chk_all("ar_pulse", 1'b1, 8'd9, 1'b0, 4);
    #1;
    rst = 1'b0;
    #1;
    chk_all("ar_async", 1'b0, 8'd0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1; br = 1'b1; op = C_BAL; pc = 8'd11; imm = 32'd0;
    @(posedge clk);
    #1;
    chk_all("ar_idle", 1'b1, 8'd11, 1'b0, 1);
    drive(1'b0, C_BAL, 8'd0, 32'd0, 32'd0, 32'd0);
    chk_all("ar_end", 1'b0, 8'd11, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
